// File: rtl/dmem_responder_if.sv
// Memory-access bus between the MA stage (master) and the data-memory
// responder (slave): request, address, store data, access type, and the
// registered completion signals.
interface dmem_responder_if;
    logic        memR;
    logic        memW;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mem_ctrl;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output memR, memW, addr, wdata, mem_ctrl,
        input  rdata, ready, err
    );

    modport slave (
        input  memR, memW, addr, wdata, mem_ctrl,
        output rdata, ready, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory-access stage.
// Accepts one load/store at a time, waits WAIT_CYCLES wait states, then pulses
// ready for one cycle with load data (sign/zero extended) or err. Stores merge
// byte/half lanes into the addressed word on the edge that leaves RESP.
// Optional feature: define DMEM_MISALIGN_ERR_EN to reject misaligned half/word
// accesses with err; otherwise the low address bits are dropped for them.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // funct3 encodings with no defined access width
    function automatic logic ctrl_illegal(input logic [2:0] c);
        case (c)
            3'b011, 3'b110, 3'b111: ctrl_illegal = 1'b1;
            default:                ctrl_illegal = 1'b0;
        endcase
    endfunction

`ifdef DMEM_MISALIGN_ERR_EN
    // half needs addr[0]=0, word needs addr[1:0]=0
    function automatic logic misaligned(input logic [2:0] c, input logic [1:0] a);
        case (c[1:0])
            2'b01:   misaligned = a[0];
            2'b10:   misaligned = (a != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction
`endif

    // Select and extend the addressed byte/half of a word; half ignores a[0], word ignores a[1:0]
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  c,
                                                 input logic [1:0]  a);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        case (c)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b100:  load_extract = {24'h000000, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b101:  load_extract = {16'h0000, h};
            3'b010:  load_extract = word;
            default: load_extract = 32'h0000_0000;
        endcase
    endfunction

    // Merge right-aligned store data into the old word on the selected lanes
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] d,
                                                input logic [2:0]  c,
                                                input logic [1:0]  a);
        logic [31:0] r;
        r = old;
        case (c[1:0])
            2'b00: begin
                case (a)
                    2'b00:   r[7:0]   = d[7:0];
                    2'b01:   r[15:8]  = d[7:0];
                    2'b10:   r[23:16] = d[7:0];
                    2'b11:   r[31:24] = d[7:0];
                    default: r = old;
                endcase
            end
            2'b01: begin
                if (a[1]) begin
                    r[31:16] = d[15:0];
                end else begin
                    r[15:0] = d[15:0];
                end
            end
            2'b10:   r = d;
            default: r = old;
        endcase
        store_merge = r;
    endfunction

    logic [31:0]      mem_q [DEPTH_WORDS];

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W+1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             store_q, store_d;
    logic             bad_q, bad_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             req_s;
    logic             acc_bad_s;
    logic [IDX_W+1:0] cur_addr_s;
    logic [2:0]       cur_ctrl_s;
    logic             cur_store_s;
    logic             cur_bad_s;
    logic [31:0]      cur_word_s;

    // Classify the incoming request and pick the access that will be answered next
    // (live bus in IDLE so a zero-wait-state access can respond the very next cycle)
    always_comb begin
        req_s     = bus.memR | bus.memW;
        acc_bad_s = ctrl_illegal(bus.mem_ctrl) | (bus.memR & bus.memW);
`ifdef DMEM_MISALIGN_ERR_EN
        acc_bad_s = acc_bad_s | misaligned(bus.mem_ctrl, bus.addr[1:0]);
`endif
        if (state_q == ST_IDLE) begin
            cur_addr_s  = bus.addr[IDX_W+1:0];
            cur_ctrl_s  = bus.mem_ctrl;
            cur_store_s = bus.memW;
            cur_bad_s   = acc_bad_s;
        end else begin
            cur_addr_s  = addr_q;
            cur_ctrl_s  = ctrl_q;
            cur_store_s = store_q;
            cur_bad_s   = bad_q;
        end
        cur_word_s = mem_q[cur_addr_s[IDX_W+1:2]];
    end

    // Next-state logic: acceptance latch, wait-state countdown, single response cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ctrl_d  = ctrl_q;
        store_d = store_q;
        bad_d   = bad_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    addr_d  = bus.addr[IDX_W+1:0];
                    wdata_d = bus.wdata;
                    ctrl_d  = bus.mem_ctrl;
                    store_d = bus.memW;
                    bad_d   = acc_bad_s;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_INIT == 4'd0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: outputs are computed for the cycle being entered so they can be registered
    always_comb begin
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'h0000_0000;
        if (state_d == ST_RESP) begin
            ready_d = 1'b1;
            err_d   = cur_bad_s;
            if (!cur_bad_s && !cur_store_s) begin
                rdata_d = load_extract(cur_word_s, cur_ctrl_s, cur_addr_s[1:0]);
            end else begin
                rdata_d = 32'h0000_0000;
            end
        end else begin
            ready_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            ctrl_q  <= 3'b000;
            store_q <= 1'b0;
            bad_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ctrl_q  <= ctrl_d;
            store_q <= store_d;
            bad_q   <= bad_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Store commit on the edge leaving RESP; a reset on that edge aborts it
    always_ff @(posedge clk) begin
        if (!reset && (state_q == ST_RESP) && store_q && !bad_q) begin
            mem_q[addr_q[IDX_W+1:2]] <= store_merge(mem_q[addr_q[IDX_W+1:2]],
                                                    wdata_q, ctrl_q, addr_q[1:0]);
        end
    end

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic compared against a byte-addressed reference memory.
module tb_dmem_responder;
    localparam int W = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // 4 KiB of byte storage = 1024 words; addresses alias modulo 4096
    logic [7:0] mdl [0:4095];

    logic [31:0] rd;
    logic        er;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, access size from funct3, alignment by rounding down
    task automatic model_txn(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [2:0] c,
                             output logic e, output logic [31:0] exp_rd);
        int          sz;
        int          ba;
        logic        mis;
        logic [31:0] v;
        sz  = (c[1:0] == 2'd0) ? 1 : ((c[1:0] == 2'd1) ? 2 : 4);
        mis = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        mis = ((int'(a[1:0]) % sz) != 0);
`endif
        e  = (c == 3'b011) || (c == 3'b110) || (c == 3'b111) || (r && w) || mis;
        ba = int'(a[11:0]);
        ba = ba - (ba % sz);
        v  = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(mdl[ba + i]) << (8 * i));
        if (!c[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!c[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
        exp_rd = (e || w) ? 32'h0 : v;
        if (w && !e) begin
            for (int i = 0; i < sz; i++) mdl[ba + i] = d[8 * i +: 8];
        end
    endtask

    // One complete transaction; starts and ends just after a falling edge with the DUT idle
    task automatic run_txn(input string tag, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d, input logic [2:0] c,
                           output logic [31:0] got_rd, output logic got_err);
        logic        e;
        logic [31:0] exp_rd;
        int          cnt;
        bit          seen;
        model_txn(r, w, a, d, c, e, exp_rd);
        bus.memR = r; bus.memW = w; bus.addr = a; bus.wdata = d; bus.mem_ctrl = c;
        @(posedge clk);
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt <= W + 8) begin
            @(negedge clk);
            if (bus.ready === 1'b1) seen = 1'b1;
            else cnt++;
        end
        check_eq({tag, ".ready_seen"}, 32'(seen), 32'd1);
        check_eq({tag, ".latency"}, cnt, W);
        got_rd  = bus.rdata;
        got_err = bus.err;
        check_eq({tag, ".err"}, 32'(got_err), 32'(e));
        check_eq({tag, ".rdata"}, got_rd, exp_rd);
        bus.memR = 1'b0;
        bus.memW = 1'b0;
        @(negedge clk);
        check_eq({tag, ".pulse_end"}, 32'(bus.ready), 32'd0);
    endtask

    initial begin
        logic        r, w;
        logic [2:0]  c;
        logic [31:0] a;
        bit          seen;

        reset = 1'b1;
        bus.memR = 1'b0; bus.memW = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0; bus.mem_ctrl = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset.ready", 32'(bus.ready), 32'd0);
        check_eq("reset.err",   32'(bus.err),   32'd0);
        check_eq("reset.rdata", bus.rdata,      32'h0);
        reset = 1'b0;
        @(negedge clk);

        // 1: basic word store / load
        run_txn("t1_sw", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er);
        check_eq("t1_sw_err", 32'(er), 32'd0);
        run_txn("t1_lw", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, rd, er);
        check_eq("t1_lw_data", rd, 32'hDEADBEEF);

        // 2: byte store merge and byte loads
        run_txn("t2_sw",  1'b0, 1'b1, 32'h20, 32'h11223344, 3'b010, rd, er);
        run_txn("t2_sb",  1'b0, 1'b1, 32'h22, 32'h000000AA, 3'b000, rd, er);
        run_txn("t2_lw",  1'b1, 1'b0, 32'h20, 32'h0, 3'b010, rd, er);
        check_eq("t2_lw_data", rd, 32'h11AA3344);
        run_txn("t2_lb",  1'b1, 1'b0, 32'h22, 32'h0, 3'b000, rd, er);
        check_eq("t2_lb_data", rd, 32'hFFFFFFAA);
        run_txn("t2_lbu", 1'b1, 1'b0, 32'h22, 32'h0, 3'b100, rd, er);
        check_eq("t2_lbu_data", rd, 32'h000000AA);

        // 3: upper half store and half loads
        run_txn("t3_sw",  1'b0, 1'b1, 32'h30, 32'h0, 3'b010, rd, er);
        run_txn("t3_sh",  1'b0, 1'b1, 32'h32, 32'h00008001, 3'b001, rd, er);
        run_txn("t3_lh",  1'b1, 1'b0, 32'h32, 32'h0, 3'b001, rd, er);
        check_eq("t3_lh_data", rd, 32'hFFFF8001);
        run_txn("t3_lhu", 1'b1, 1'b0, 32'h32, 32'h0, 3'b101, rd, er);
        check_eq("t3_lhu_data", rd, 32'h00008001);
        run_txn("t3_lw",  1'b1, 1'b0, 32'h30, 32'h0, 3'b010, rd, er);
        check_eq("t3_lw_data", rd, 32'h80010000);

        // 4: illegal funct3 and dual request are rejected without writing
        run_txn("t4_sw",   1'b0, 1'b1, 32'h40, 32'h5, 3'b010, rd, er);
        run_txn("t4_ill",  1'b0, 1'b1, 32'h40, 32'h77, 3'b011, rd, er);
        check_eq("t4_ill_err", 32'(er), 32'd1);
        run_txn("t4_lw1",  1'b1, 1'b0, 32'h40, 32'h0, 3'b010, rd, er);
        check_eq("t4_lw1_data", rd, 32'h5);
        run_txn("t4_dual", 1'b1, 1'b1, 32'h40, 32'h99, 3'b010, rd, er);
        check_eq("t4_dual_err", 32'(er), 32'd1);
        run_txn("t4_lw2",  1'b1, 1'b0, 32'h40, 32'h0, 3'b010, rd, er);
        check_eq("t4_lw2_data", rd, 32'h5);

        // 5: misaligned word load
        run_txn("t5_lw", 1'b1, 1'b0, 32'h41, 32'h0, 3'b010, rd, er);
`ifdef DMEM_MISALIGN_ERR_EN
        check_eq("t5_err", 32'(er), 32'd1);
        check_eq("t5_data", rd, 32'h0);
`else
        check_eq("t5_err", 32'(er), 32'd0);
        check_eq("t5_data", rd, 32'h5);
`endif

        // 6: address aliasing, then reset during a store's wait states
        run_txn("t6_alias", 1'b1, 1'b0, 32'h1010, 32'h0, 3'b010, rd, er);
        check_eq("t6_alias_data", rd, 32'hDEADBEEF);
        run_txn("t6_sw_old", 1'b0, 1'b1, 32'h50, 32'h1, 3'b010, rd, er);
        bus.memW = 1'b1; bus.addr = 32'h50; bus.wdata = 32'h9; bus.mem_ctrl = 3'b010;
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        bus.memW = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (bus.ready !== 1'b0) seen = 1'b1;
        end
        check_eq("t6_abort_noready", 32'(seen), 32'd0);
        check_eq("t6_abort_rdata", bus.rdata, 32'h0);
        run_txn("t6_lw", 1'b1, 1'b0, 32'h50, 32'h0, 3'b010, rd, er);
        check_eq("t6_lw_data", rd, 32'h1);

        // Fill the first 64 words, then random mixed traffic over them (with aliasing high bits)
        for (int i = 0; i < 64; i++) begin
            run_txn("fill", 1'b0, 1'b1, 32'(i * 4), $urandom, 3'b010, rd, er);
        end
        for (int n = 0; n < 200; n++) begin
            r = 1'($urandom_range(0, 1));
            w = ~r;
            if ($urandom_range(0, 9) == 0) begin
                r = 1'b1;
                w = 1'b1;
            end
            c = 3'($urandom_range(0, 7));
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            run_txn("rand", r, w, a, $urandom, c, rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
